// File: rtl/montmul_digit_sched.sv
// montmul_digit_sched: walks the radix-2^54 digits of B, launching multiply then reduction per digit with watchdogs.
module montmul_digit_sched #(
   parameter int SIZE    = 3072,
   parameter int RADIX   = 54,
   parameter int DIGITS  = 57,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [SIZE+1:0]   b,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [5:0]        digit_idx,
   output logic [RADIX-1:0]  mul_bi,
   output logic              mul_en,
   input  logic              mul_done,
   output logic              red_en,
   input  logic              red_done
);
   localparam int SW = DIGITS * RADIX;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE = 2'd0, WAIT_MUL = 2'd1, WAIT_RED = 2'd2, ERR = 2'd3;
   logic [1:0]    state;
   logic [SW-1:0] sr;
   logic [WW-1:0] wd;
   logic          timeout, last;
   assign timeout = wd == WW'(TIMEOUT);
   assign last    = digit_idx == 6'(DIGITS - 1);
   assign mul_bi  = sr[RADIX-1:0];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sr        <= '0;
         wd        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         digit_idx <= '0;
         mul_en    <= 1'b0;
         red_en    <= 1'b0;
      end else begin
         mul_en <= 1'b0;
         red_en <= 1'b0;
         done   <= 1'b0;
         if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE, ERR: begin
                  // done still high means this is the completion cycle; start waits one more cycle
                  if (start && !done) begin
                     sr        <= SW'(b);
                     digit_idx <= '0;
                     busy      <= 1'b1;
                     err       <= 1'b0;
                     mul_en    <= 1'b1;
                     wd        <= '0;
                     state     <= WAIT_MUL;
                  end
               end
               WAIT_MUL: begin
                  if (mul_done && !mul_en) begin
                     red_en <= 1'b1;
                     wd     <= '0;
                     state  <= WAIT_RED;
                  end else if (timeout) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= ERR;
                  end else
                     wd <= wd + 1'b1;
               end
               WAIT_RED: begin
                  if (red_done && last) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else if (red_done) begin
                     digit_idx <= digit_idx + 6'd1;
                     sr        <= sr >> RADIX;
                     mul_en    <= 1'b1;
                     wd        <= '0;
                     state     <= WAIT_MUL;
                  end else if (timeout) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= ERR;
                  end else
                     wd <= wd + 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_montmul_digit_sched.sv
// tb_montmul_digit_sched: directed checks of the digit sequencer with a fixed-latency stage responder.
module tb_montmul_digit_sched;
   localparam int SIZE = 3072, RADIX = 54, DIGITS = 57;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, mul_done = 1'b0, red_done = 1'b0;
   logic [SIZE+1:0] b = '0;
   logic busy, done, err, mul_en, red_en;
   logic [5:0] digit_idx;
   logic [RADIX-1:0] mul_bi;
   logic [SIZE+1:0] bv;
   logic [DIGITS*RADIX-1:0] ext, pat;
   logic [RADIX-1:0] cur_digit;
   int total = 0, bad = 0;
   int cyc, n_mul, n_red, n_done, done_cyc, last_mul, mul_due, red_due, busy_bad, hold_cyc, kk;
   bit chk_busy = 0, hold_en = 0;
   montmul_digit_sched dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .b(b),
      .busy(busy), .done(done), .err(err), .digit_idx(digit_idx), .mul_bi(mul_bi),
      .mul_en(mul_en), .mul_done(mul_done), .red_en(red_en), .red_done(red_done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask
   // one cycle: sample outputs at negedge, then drive the stage responses
   task automatic tick();
      @(negedge clk);
      cyc++;
      start = 1'b0; abort = 1'b0; mul_done = 1'b0; red_done = 1'b0;
      if (mul_en) begin
         kk = n_mul % DIGITS;
         n_mul++;
         last_mul = cyc;
         cur_digit = ext[RADIX*kk +: RADIX];
         check("digit_idx", 64'(digit_idx), 64'(kk));
         check("mul_bi", 64'(mul_bi), 64'(cur_digit));
         if (kk == DIGITS - 1) check("top4_zero", 64'(mul_bi[RADIX-1:RADIX-4]), 64'd0);
         if (hold_en && kk == 3) begin
            mul_due = -1;
            hold_cyc = cyc;
         end else
            mul_due = cyc + 6;
      end
      if (red_en) begin
         n_red++;
         red_due = cyc + 2;
         check("mul_bi_stable", 64'(mul_bi), 64'(cur_digit));
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (chk_busy && busy !== (cyc >= 1 && cyc <= 570)) busy_bad++;
      if (cyc == mul_due) mul_done = 1'b1;
      if (cyc == red_due) red_done = 1'b1;
   endtask
   task automatic launch();
      b = bv; ext = (DIGITS*RADIX)'(bv); start = 1'b1;
      cyc = 0; n_mul = 0; n_red = 0; n_done = 0; done_cyc = -1; last_mul = -10;
      mul_due = -1; red_due = -1; busy_bad = 0; hold_cyc = -1;
   endtask
   task automatic run_full(input string tag, input bit robust);
      launch();
      chk_busy = 1;
      repeat (575) begin
         tick();
         if (cyc == 1) check({tag, "_err_clear"}, 64'(err), 64'd0);
         if (robust && mul_en) mul_done = 1'b1;
         if (robust && cyc == last_mul + 3) red_done = 1'b1;
         if (robust && busy && cyc % 37 == 5) start = 1'b1;
         if (robust && done) start = 1'b1;
      end
      chk_busy = 0;
      check({tag, "_n_mul"}, 64'(n_mul), 64'd57);
      check({tag, "_n_red"}, 64'(n_red), 64'd57);
      check({tag, "_n_done"}, 64'(n_done), 64'd1);
      check({tag, "_done_cyc"}, 64'(done_cyc), 64'd571);
      check({tag, "_last_mul"}, 64'(last_mul), 64'd561);
      check({tag, "_busy_bad"}, 64'(busy_bad), 64'd0);
   endtask
   initial begin
      int sm, sr_, sd;
      for (int i = 0; i < DIGITS*RADIX/8; i++) pat[8*i +: 8] = 8'(i * 7 + 1);
      pat[DIGITS*RADIX-1 -: 8] = 8'hff;
      bv = pat[SIZE+1:0];
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_idx", 64'(digit_idx), 64'd0);
      check("rst_mul_bi", 64'(mul_bi), 64'd0);
      check("rst_mul_en", 64'(mul_en), 64'd0);
      check("rst_red_en", 64'(red_en), 64'd0);
      rst_n = 1'b1;
      tick();
      run_full("full", 0);
      // watchdog on digit 3 multiply
      hold_en = 1;
      launch();
      tick();
      while (hold_cyc < 0 && cyc < 200) tick();
      check("wd_seen", 64'(hold_cyc), 64'd31);
      while (cyc < hold_cyc + 15 && cyc < 300) tick();
      check("wd_err_early", 64'(err), 64'd0);
      tick();
      check("wd_err", 64'(err), 64'd1);
      check("wd_busy", 64'(busy), 64'd0);
      hold_en = 0;
      sm = n_mul; sr_ = n_red;
      repeat (10) tick();
      check("wd_no_mul", 64'(n_mul), 64'(sm));
      check("wd_no_red", 64'(n_red), 64'(sr_));
      check("wd_err_sticky", 64'(err), 64'd1);
      bv = ~pat[SIZE+1:0];
      run_full("after_err", 0);
      // abort together with red_done on digit 20
      launch();
      tick();
      while (!(n_red == 21 && cyc == red_due) && cyc < 400) tick();
      check("ab_cyc", 64'(cyc), 64'd210);
      abort = 1'b1;
      tick();
      check("ab_busy", 64'(busy), 64'd0);
      check("ab_mul_en", 64'(mul_en), 64'd0);
      check("ab_done", 64'(done), 64'd0);
      sm = n_mul; sr_ = n_red; sd = n_done;
      repeat (5) tick();
      check("ab_no_mul", 64'(n_mul), 64'(sm));
      check("ab_no_red", 64'(n_red), 64'(sr_));
      check("ab_no_done", 64'(n_done), 64'(sd));
      bv = pat[SIZE+1:0];
      run_full("after_abort", 0);
      run_full("robust", 1);
      // synchronous reset at digit 40
      launch();
      tick();
      while (n_mul < 41 && cyc < 500) tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_done", 64'(done), 64'd0);
      check("mrst_err", 64'(err), 64'd0);
      check("mrst_idx", 64'(digit_idx), 64'd0);
      check("mrst_mul_bi", 64'(mul_bi), 64'd0);
      check("mrst_mul_en", 64'(mul_en), 64'd0);
      check("mrst_red_en", 64'(red_en), 64'd0);
      tick();
      run_full("after_reset", 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
